// File: rtl/timer_irq_ctrl_pkg.sv
// Shared constants for the timer interrupt path: default counter width and
// the status bit layout the APB register block uses to pack sts_* flags.
package timer_irq_ctrl_pkg;

    localparam int CNT_W_DEF   = 8;

    localparam int STS_OVF     = 0;
    localparam int STS_UDF     = 1;
    localparam int STS_OVF_OVR = 2;
    localparam int STS_UDF_OVR = 3;
    localparam int STS_W       = 4;

    function automatic logic [STS_W-1:0] pack_sts(input logic ovf, input logic udf,
                                                  input logic ovf_ovr, input logic udf_ovr);
        logic [STS_W-1:0] v;
        v              = '0;
        v[STS_OVF]     = ovf;
        v[STS_UDF]     = udf;
        v[STS_OVF_OVR] = ovf_ovr;
        v[STS_UDF_OVR] = udf_ovr;
        return v;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Signal bundle between the counter/register block (master) and the
// interrupt controller (slave). Plain level signals and one-cycle clear pulses; no handshake.
interface timer_irq_ctrl_if #(parameter int CNT_W = 8);

    logic [CNT_W-1:0] cnt_in;
    logic             load;
    logic             dw;
    logic             ie_ovf;
    logic             ie_udf;
    logic             clr_ovf;
    logic             clr_udf;
    logic             sts_ovf;
    logic             sts_udf;
    logic             sts_ovf_ovr;
    logic             sts_udf_ovr;
    logic             irq;

    modport master (
        output cnt_in, load, dw, ie_ovf, ie_udf, clr_ovf, clr_udf,
        input  sts_ovf, sts_udf, sts_ovf_ovr, sts_udf_ovr, irq
    );

    modport slave (
        input  cnt_in, load, dw, ie_ovf, ie_udf, clr_ovf, clr_udf,
        output sts_ovf, sts_udf, sts_ovf_ovr, sts_udf_ovr, irq
    );

endinterface

// File: rtl/timer_wrap_det.sv
// Registers one cycle of counter history and flags a wrap in the direction
// that was in force when the counter stepped.
module timer_wrap_det #(
    parameter int CNT_W = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             load,
    input  logic             dw,
    output logic             ovf_evt,
    output logic             udf_evt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic             load_q;
    logic             dw_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q  <= '0;
            load_q <= 1'b0;
            dw_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_in;
            load_q <= load;
            dw_q   <= dw;
        end
    end

    // A loaded value is never a wrap, whatever the numbers look like.
    always_comb begin
        ovf_evt = ~load_q & ~dw_q & (cnt_q == CNT_MAX) & (cnt_in == '0);
        udf_evt = ~load_q &  dw_q & (cnt_q == '0)      & (cnt_in == CNT_MAX);
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Sticky overflow/underflow status with overrun tracking and a maskable
// level interrupt for the timer register block.
module timer_irq_ctrl
    import timer_irq_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          pclk,
    input  logic          presetn,
    timer_irq_ctrl_if.slave bus
);

    logic ovf_evt;
    logic udf_evt;
    logic sts_ovf_q, sts_udf_q, ovf_ovr_q, udf_ovr_q;
    logic sts_ovf_d, sts_udf_d, ovf_ovr_d, udf_ovr_d;

    timer_wrap_det #(.CNT_W(CNT_W)) u_wrap_det (
        .pclk    (pclk),
        .presetn (presetn),
        .cnt_in  (bus.cnt_in),
        .load    (bus.load),
        .dw      (bus.dw),
        .ovf_evt (ovf_evt),
        .udf_evt (udf_evt)
    );

    // Set beats clear; an event landing on a clear restarts the flag, not an overrun.
    always_comb begin
        sts_ovf_d = ovf_evt | (sts_ovf_q & ~bus.clr_ovf);
        sts_udf_d = udf_evt | (sts_udf_q & ~bus.clr_udf);
        ovf_ovr_d = ((ovf_evt & sts_ovf_q) | ovf_ovr_q) & ~bus.clr_ovf;
        udf_ovr_d = ((udf_evt & sts_udf_q) | udf_ovr_q) & ~bus.clr_udf;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sts_ovf_q <= 1'b0;
            sts_udf_q <= 1'b0;
            ovf_ovr_q <= 1'b0;
            udf_ovr_q <= 1'b0;
        end else begin
            sts_ovf_q <= sts_ovf_d;
            sts_udf_q <= sts_udf_d;
            ovf_ovr_q <= ovf_ovr_d;
            udf_ovr_q <= udf_ovr_d;
        end
    end

    // irq sees only flops and enables, so cnt_in has no path to it.
    assign bus.irq         = (sts_ovf_q & bus.ie_ovf) | (sts_udf_q & bus.ie_udf);
    assign bus.sts_ovf     = sts_ovf_q;
    assign bus.sts_udf     = sts_udf_q;
    assign bus.sts_ovf_ovr = ovf_ovr_q;
    assign bus.sts_udf_ovr = udf_ovr_q;

endmodule
